// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite scanline buffer.
`default_nettype none

package sprite_pkg;

  localparam int unsigned DEF_LINE_W       = 640;
  localparam logic [15:0] DEF_TRANSP_COLOR = 16'h0000;

  typedef logic [15:0] pixel_t;
  typedef logic [9:0]  col_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    FILL  = 3'd2,
    DRAIN = 3'd3,
    READY = 3'd4
  } linebuf_state_t;

endpackage

`default_nettype wire

// File: rtl/sprite_line_bank.sv
// One scanline bank: pixel RAM, per-column valid flags, one write port, one registered read port.
// Optional SPRITE_LINEBUF_PRIO_EN: writes to an already-valid column are dropped (first writer wins).
`default_nettype none

module sprite_line_bank
  import sprite_pkg::*;
#(
  parameter int unsigned LINE_W       = DEF_LINE_W,
  parameter pixel_t      TRANSP_COLOR = DEF_TRANSP_COLOR
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   clear_all,
  input  logic   wr_en,
  input  col_t   wr_col,
  input  pixel_t wr_data,
  input  logic   rd_en,
  input  col_t   rd_col,
  output pixel_t rd_pixel,
  output logic   rd_opaque
);

  localparam col_t LAST_COL = col_t'(LINE_W - 1);

  pixel_t            mem [LINE_W];
  logic [LINE_W-1:0] valid;
  logic              wr_go;
  logic              rd_in_range;

  assign rd_in_range = (rd_col <= LAST_COL);

`ifdef SPRITE_LINEBUF_PRIO_EN
  assign wr_go = wr_en && !valid[wr_col];
`else
  assign wr_go = wr_en;
`endif

  always_ff @(posedge clk) begin
    if (wr_go) begin
      mem[wr_col] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
    end else if (clear_all) begin
      valid <= '0;
    end else if (wr_go) begin
      valid[wr_col] <= 1'b1;
    end
  end

  // Unwritten or out-of-range columns read as transparent, never as stale RAM contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pixel  <= '0;
      rd_opaque <= 1'b0;
    end else if (rd_en) begin
      if (rd_in_range && valid[rd_col]) begin
        rd_pixel  <= mem[rd_col];
        rd_opaque <= 1'b1;
      end else begin
        rd_pixel  <= TRANSP_COLOR;
        rd_opaque <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sprite_linebuf.sv
// Ping-pong scanline buffer between sprite_engine and VGA scanout: FSM, bank select, status.
// Optional SPRITE_LINEBUF_PRIO_EN selects first-writer-wins inside the banks.
`default_nettype none

module sprite_linebuf
  import sprite_pkg::*;
#(
  parameter int unsigned LINE_W       = DEF_LINE_W,
  parameter pixel_t      TRANSP_COLOR = DEF_TRANSP_COLOR
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   line_start,
  input  col_t   next_vcount,
  output logic   sprite_start,
  output col_t   sprite_vcount,
  input  col_t   sprite_pixel_col,
  input  pixel_t sprite_pixel_data,
  input  logic   wren_pixel_draw,
  input  logic   done,
  input  logic   disp_rd,
  input  col_t   disp_col,
  output pixel_t disp_pixel,
  output logic   disp_opaque,
  output logic   overrun,
  input  logic   clr_status,
  output logic   busy
);

  localparam col_t LAST_COL = col_t'(LINE_W - 1);

  linebuf_state_t state;
  linebuf_state_t state_next;
  logic           set_overrun;
  logic           front;
  logic           rd_bank;
  logic           wr_accept;
  pixel_t         bank_pixel [2];
  logic [1:0]     bank_opaque;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    set_overrun = 1'b0;
    if (line_start) begin
      case (state)
        FILL: begin
          // done in the same cycle still counts as a completed fill
          if (done) begin
            state_next = START;
          end else begin
            state_next  = DRAIN;
            set_overrun = 1'b1;
          end
        end
        DRAIN: begin
          state_next  = DRAIN;
          set_overrun = 1'b1;
        end
        default: state_next = START;
      endcase
    end else begin
      case (state)
        START:   state_next = FILL;
        FILL:    if (done) state_next = READY;
        DRAIN:   if (done) state_next = START;
        default: state_next = state;
      endcase
    end
  end

  assign sprite_start = (state == START);
  assign busy         = (state == START) || (state == FILL) || (state == DRAIN);

  assign wr_accept = (state == FILL) && wren_pixel_draw &&
                     (sprite_pixel_col <= LAST_COL) &&
                     (sprite_pixel_data != TRANSP_COLOR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      front         <= 1'b0;
      sprite_vcount <= '0;
      overrun       <= 1'b0;
      rd_bank       <= 1'b0;
    end else begin
      if (line_start) begin
        front         <= ~front;
        sprite_vcount <= next_vcount;
      end
      if (set_overrun) begin
        overrun <= 1'b1;
      end else if (clr_status) begin
        overrun <= 1'b0;
      end
      if (disp_rd) begin
        rd_bank <= front;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic is_front;
    assign is_front = (front == 1'(b));

    sprite_line_bank #(
      .LINE_W       (LINE_W),
      .TRANSP_COLOR (TRANSP_COLOR)
    ) u_bank (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear_all (line_start && is_front),
      .wr_en     (wr_accept && !is_front),
      .wr_col    (sprite_pixel_col),
      .wr_data   (sprite_pixel_data),
      .rd_en     (disp_rd && is_front),
      .rd_col    (disp_col),
      .rd_pixel  (bank_pixel[b]),
      .rd_opaque (bank_opaque[b])
    );
  end

  assign disp_pixel  = bank_pixel[rd_bank];
  assign disp_opaque = bank_opaque[rd_bank];

endmodule

`default_nettype wire

// File: tb/tb_sprite_linebuf.sv
// Randomized bench for sprite_linebuf against a behavioural line-buffer model.
`default_nettype none

module tb_sprite_linebuf;
  import sprite_pkg::*;

  localparam int LW = 640;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  next_vcount = '0;
  logic        sprite_start;
  logic [9:0]  sprite_vcount;
  logic [9:0]  sprite_pixel_col = '0;
  logic [15:0] sprite_pixel_data = '0;
  logic        wren_pixel_draw = 1'b0;
  logic        done = 1'b0;
  logic        disp_rd = 1'b0;
  logic [9:0]  disp_col = '0;
  logic [15:0] disp_pixel;
  logic        disp_opaque;
  logic        overrun;
  logic        clr_status = 1'b0;
  logic        busy;

  always #5 clk = ~clk;

  sprite_linebuf dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .line_start        (line_start),
    .next_vcount       (next_vcount),
    .sprite_start      (sprite_start),
    .sprite_vcount     (sprite_vcount),
    .sprite_pixel_col  (sprite_pixel_col),
    .sprite_pixel_data (sprite_pixel_data),
    .wren_pixel_draw   (wren_pixel_draw),
    .done              (done),
    .disp_rd           (disp_rd),
    .disp_col          (disp_col),
    .disp_pixel        (disp_pixel),
    .disp_opaque       (disp_opaque),
    .overrun           (overrun),
    .clr_status        (clr_status),
    .busy              (busy)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: two line arrays, which one the display sees, and the engine phase.
  localparam int PH_IDLE = 0, PH_START = 1, PH_FILL = 2, PH_DRAIN = 3, PH_READY = 4;
  int          ph;
  bit          mfront;
  logic [15:0] mdata  [2][LW];
  bit          mvalid [2][LW];
  logic [9:0]  m_vc;
  bit          m_ov;
  logic [15:0] m_pix;
  bit          m_opq;
  bit          acc;
  bit          ov_set;
  int          wc;
  int          rc;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph = PH_IDLE; mfront = 1'b0; m_vc = '0; m_ov = 1'b0; m_pix = '0; m_opq = 1'b0;
      for (int i = 0; i < LW; i++) begin
        mvalid[0][i] = 1'b0;
        mvalid[1][i] = 1'b0;
      end
    end else begin
      if (disp_rd) begin
        rc = int'(disp_col);
        if (rc < LW && mvalid[mfront][rc]) begin
          m_pix = mdata[mfront][rc]; m_opq = 1'b1;
        end else begin
          m_pix = 16'h0000; m_opq = 1'b0;
        end
      end
      wc  = int'(sprite_pixel_col);
      acc = (ph == PH_FILL) && wren_pixel_draw && (wc < LW) && (sprite_pixel_data != 16'h0000);
`ifdef SPRITE_LINEBUF_PRIO_EN
      if (acc && mvalid[~mfront][wc]) acc = 1'b0;
`endif
      if (acc) begin
        mdata[~mfront][wc]  = sprite_pixel_data;
        mvalid[~mfront][wc] = 1'b1;
      end
      ov_set = line_start && ((ph == PH_FILL && !done) || ph == PH_DRAIN);
      if (ov_set) m_ov = 1'b1;
      else if (clr_status) m_ov = 1'b0;
      if (line_start) begin
        if (ph == PH_FILL && !done) ph = PH_DRAIN;
        else if (ph != PH_DRAIN) ph = PH_START;
        for (int i = 0; i < LW; i++) mvalid[mfront][i] = 1'b0;
        mfront = ~mfront;
        m_vc   = next_vcount;
      end else begin
        if (ph == PH_START) ph = PH_FILL;
        else if (ph == PH_FILL && done) ph = PH_READY;
        else if (ph == PH_DRAIN && done) ph = PH_START;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("sprite_start",  {31'd0, sprite_start}, {31'd0, ph == PH_START});
      check("busy",          {31'd0, busy}, {31'd0, ph == PH_START || ph == PH_FILL || ph == PH_DRAIN});
      check("sprite_vcount", {22'd0, sprite_vcount}, {22'd0, m_vc});
      check("overrun",       {31'd0, overrun}, {31'd0, m_ov});
      check("disp_pixel",    {16'd0, disp_pixel}, {16'd0, m_pix});
      check("disp_opaque",   {31'd0, disp_opaque}, {31'd0, m_opq});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    line_start = 1'b0; wren_pixel_draw = 1'b0; done = 1'b0; disp_rd = 1'b0; clr_status = 1'b0;
  endtask

  task automatic wr(input int col, input logic [15:0] data);
    wren_pixel_draw = 1'b1; sprite_pixel_col = 10'(col); sprite_pixel_data = data;
    step();
  endtask

  task automatic rd(input int col);
    disp_rd = 1'b1; disp_col = 10'(col);
    step();
  endtask

  task automatic ls(input int vc);
    line_start = 1'b1; next_vcount = 10'(vc);
    step();
  endtask

  task automatic dn();
    done = 1'b1;
    step();
  endtask

  task automatic lit_rd(input string name, input logic [15:0] pix, input bit opq);
    check({name, "_pix"}, {16'd0, disp_pixel}, {16'd0, pix});
    check({name, "_opq"}, {31'd0, disp_opaque}, {31'd0, opq});
    check({name, "_model_pix"}, {16'd0, m_pix}, {16'd0, pix});
  endtask

  initial begin
    int r;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk_en = 1'b1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_pixel", {16'd0, disp_pixel}, 32'd0);

    ls(100);
    check("ls_start", {31'd0, sprite_start}, 32'd1);
    check("ls_vcount", {22'd0, sprite_vcount}, 32'd100);
    check("ls_busy", {31'd0, busy}, 32'd1);
    rd(5);
    check("start_once", {31'd0, sprite_start}, 32'd0);
    lit_rd("empty_c5", 16'h0000, 1'b0);

    wr(5, 16'h1234); wr(639, 16'hFFFF); wr(7, 16'h0000); wr(700, 16'hABCD);
    wr(10, 16'h1111); wr(10, 16'h2222);
    dn();
    check("ready_busy", {31'd0, busy}, 32'd0);
    ls(101);
    step();
    rd(5);   lit_rd("c5", 16'h1234, 1'b1);
    rd(639); lit_rd("c639", 16'hFFFF, 1'b1);
    rd(6);   lit_rd("c6", 16'h0000, 1'b0);
    rd(7);   lit_rd("c7_transp", 16'h0000, 1'b0);
    rd(60);  lit_rd("c60_alias", 16'h0000, 1'b0);
    rd(700); lit_rd("c700_oor", 16'h0000, 1'b0);
    rd(10);
`ifdef SPRITE_LINEBUF_PRIO_EN
    lit_rd("c10_prio", 16'h1111, 1'b1);
    step();
    lit_rd("c10_hold", 16'h1111, 1'b1);
`else
    lit_rd("c10_last", 16'h2222, 1'b1);
    step();
    lit_rd("c10_hold", 16'h2222, 1'b1);
`endif

    ls(102);
    check("ovr_set", {31'd0, overrun}, 32'd1);
    wr(3, 16'h3333);
    dn();
    check("late_start", {31'd0, sprite_start}, 32'd1);
    step();
    check("late_start_once", {31'd0, sprite_start}, 32'd0);
    dn();
    ls(103);
    rd(3);   lit_rd("c3_dropped", 16'h0000, 1'b0);
    check("ovr_sticky", {31'd0, overrun}, 32'd1);
    clr_status = 1'b1;
    step();
    check("ovr_clr", {31'd0, overrun}, 32'd0);
    done = 1'b1; line_start = 1'b1; next_vcount = 10'd104;
    step();
    check("done_ls_no_ovr", {31'd0, overrun}, 32'd0);
    check("done_ls_start", {31'd0, sprite_start}, 32'd1);

    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        line_start = 1'b1; next_vcount = 10'($urandom_range(0, 1023));
      end else begin
        done = ($urandom_range(0, 14) == 0);
        if ($urandom_range(0, 1) == 1) begin
          wren_pixel_draw = 1'b1;
          sprite_pixel_col = ($urandom_range(0, 9) < 8) ? 10'($urandom_range(0, 15))
                                                         : 10'($urandom_range(600, 1023));
          sprite_pixel_data = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
        end
      end
      clr_status = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 1) == 1) begin
        disp_rd = 1'b1;
        disp_col = ($urandom_range(0, 9) < 8) ? 10'($urandom_range(0, 15))
                                               : 10'($urandom_range(600, 1023));
      end
      step();
    end

    dn(); dn(); dn();
    ls(50);
    step();
    wr(2, 16'h5555);
    dn();
    ls(51);
    rd(2);   lit_rd("c2_pre_rst", 16'h5555, 1'b1);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #3 reset_n = 1'b0;
    #1;
    check("rst_start", {31'd0, sprite_start}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    check("rst_opq", {31'd0, disp_opaque}, 32'd0);
    check("rst_vcount", {22'd0, sprite_vcount}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    ls(55);
    check("post_rst_start", {31'd0, sprite_start}, 32'd1);
    check("post_rst_vcount", {22'd0, sprite_vcount}, 32'd55);
    check("post_rst_busy", {31'd0, busy}, 32'd1);
    step();
    rd(2);   lit_rd("c2_post_rst", 16'h0000, 1'b0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sprite_linebuf.md
Name: sprite_linebuf

Overview:
- Consumer end of the sprite_engine pixel-write interface; ping-pong scanline buffer between sprite_engine and the VGA scanout.
- Each line start: swaps banks, issues sprite_start/vcount for the next line, captures engine pixel writes into the back bank.
- Display reads the front bank by column with 1-cycle latency.

Parameters:
- LINE_W, 640, pixels per line; valid columns 0..LINE_W-1
- TRANSP_COLOR, 16'h0000, pixel value treated as transparent

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- line_start  in  1  one-cycle pulse at start of each line (all lines, including blanking)
- next_vcount  in  10  line to prepare; sampled on line_start
- sprite_start  out  1  one-cycle start pulse to sprite_engine
- sprite_vcount  out  10  line number driven to sprite_engine vcount
- sprite_pixel_col  in  10  engine write column
- sprite_pixel_data  in  16  engine write pixel
- wren_pixel_draw  in  1  engine write strobe
- done  in  1  engine line-complete pulse
- disp_rd  in  1  display read strobe
- disp_col  in  10  display read column
- disp_pixel  out  16  front-bank pixel; TRANSP_COLOR if not opaque
- disp_opaque  out  1  pixel written this line
- overrun  out  1  sticky: line_start arrived before fill finished
- clr_status  in  1  clears overrun
- busy  out  1  high in START/FILL/DRAIN

Behaviour:
- Reset (async, immediate): state IDLE, front bank = 0, all outputs 0, all valid bits 0, sprite_vcount 0. RAM data not reset.
- Each bank: LINE_W x 16 data RAM plus LINE_W valid flops.
- line_start (any state): front bank toggles; all valid bits of the new back bank cleared in the same cycle; next_vcount latched into sprite_vcount.
- FSM transitions on line_start:
  - from IDLE/READY/START: go to START.
  - from FILL: set overrun, go to DRAIN.
  - from DRAIN: set overrun, stay in DRAIN.
- START: sprite_start = 1 for exactly one cycle (cycle after line_start); next state FILL.
- FILL:
  - Accepted write: wren_pixel_draw=1, col < LINE_W, data != TRANSP_COLOR. Writes data to back bank and sets valid.
  - Writes failing these checks are ignored.
  - On done: go to READY.
  - done and line_start in the same cycle count as completion: no overrun; line_start rules then apply, so next state is START.
- DRAIN: all engine writes dropped; on done go to START (late start for the current back bank).
- READY/IDLE: writes and done ignored.
- Overlap without the feature: last accepted write to a column wins.
- Display read: disp_rd at cycle T returns disp_pixel/disp_opaque at T+1 from the bank that was front at T.
  - A read coincident with line_start uses the pre-swap bank.
  - disp_col >= LINE_W returns TRANSP_COLOR with opaque 0.
  - Outputs hold when disp_rd = 0.
- Display reads are non-destructive.
- overrun set has priority over a simultaneous clr_status.

Optional Feature:
- Macro SPRITE_LINEBUF_PRIO_EN.
- Defined: first-writer-wins. A FILL write to a column whose valid bit is already set is dropped, so lower sprite index (drawn first) has priority.
- Undefined: last-writer-wins, as above.

Decomposition:
- Shared package sprite_pkg:
  - LINE_W default, TRANSP_COLOR.
  - typedef pixel_t (logic [15:0]), col_t (logic [9:0]).
  - enum linebuf_state_t {IDLE, START, FILL, DRAIN, READY}.
- Sub-module sprite_line_bank, instantiated twice:
  - one data RAM, valid vector, single write port, single registered read port, single-cycle clear_all input.
- Top holds the FSM, bank select and status.

Test Plan:
- Reset release; line_start with next_vcount=100 -> sprite_vcount=100, sprite_start high exactly one cycle after line_start, busy=1; all disp reads return 0x0000, opaque 0.
- FILL writes col 5=16'h1234, col 639=16'hFFFF, then done; line_start; disp_rd col 5 -> next cycle 16'h1234 opaque 1; col 639 -> 16'hFFFF; col 6 -> 16'h0000 opaque 0.
- FILL writes col 7=16'h0000 and col 700=16'hABCD, done, swap -> col 7 opaque 0, no corruption of col 700-LINE_W alias (col 60 opaque 0).
- Col 10 written 16'h1111 then 16'h2222 -> read 16'h2222; with SPRITE_LINEBUF_PRIO_EN -> 16'h1111.
- line_start during FILL -> overrun=1, state DRAIN, a write to col 3 before done is dropped; sprite_start pulses one cycle after done; clr_status -> overrun=0.
- Assert reset_n low mid-FILL -> sprite_start, busy, overrun, disp_opaque 0 the same cycle; after release next line_start resumes normally.
